time_set_ctrl: RTL and testbench

Front-panel time-setting controller for the digital clock. It takes two raw pushbuttons, MODE and INC, and lets the user edit hours and then minutes. Finished values are handed to the clock core as a one-cycle parallel load. It also drives the core's run enable and the per-field blink controls used by the seven-segment display path.

---
 rtl/time_set_ctrl.sv | 146 ++++++++++++++
 tb/tb_time_set_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: front-panel hours/minutes editor with debounced buttons, load strobe and blink control
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_HALF      = 12500000
) (
  input  logic       clk_50MHz,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic [4:0] set_hours,
  output logic [5:0] set_minutes,
  output logic [5:0] set_seconds,
  output logic       load,
  output logic       run_en,
  output logic       blink_hours,
  output logic       blink_minutes
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [1:0] RUN         = 2'd0;
  localparam logic [1:0] SET_HOURS   = 2'd1;
  localparam logic [1:0] SET_MINUTES = 2'd2;
  localparam logic [1:0] COMMIT      = 2'd3;
  // index 0 is the mode button, index 1 the inc button
  logic [1:0]    sync1_q, sync2_q, deb_q, deb_d, press_q, press_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0]    state_q, state_d;
  logic [4:0]    hours_q, hours_d;
  logic [5:0]    minutes_q, minutes_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic          inc_acc, clr, bwrap;
  logic          run_en_q, run_en_d, load_q, load_d;
  logic          blink_h_q, blink_h_d, blink_m_q, blink_m_d;
  logic          mode_p, inc_p;

  // debounce: flip the accepted level after a full run of disagreeing samples, pulse on rising flips
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) deb_d[i] = ~deb_q[i];
        else cnt_d[i] = cnt_q[i] + CW'(1);
      end
      press_d[i] = deb_d[i] & ~deb_q[i];
    end
  end

  assign mode_p = press_q[0];
  assign inc_p  = press_q[1] & ~press_q[0];

  // edit FSM: mode steps through the fields, inc bumps the field being edited with wrap
  always_comb begin
    state_d   = state_q;
    hours_d   = hours_q;
    minutes_d = minutes_q;
    inc_acc   = 1'b0;
    case (state_q)
      RUN: if (mode_p) begin
        hours_d   = (cur_hours > 5'd23) ? 5'd0 : cur_hours;
        minutes_d = (cur_minutes > 6'd59) ? 6'd0 : cur_minutes;
        state_d   = SET_HOURS;
      end
      SET_HOURS: begin
        if (mode_p) state_d = SET_MINUTES;
        else if (inc_p) begin
          hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
          inc_acc = 1'b1;
        end
      end
      SET_MINUTES: begin
        if (mode_p) state_d = COMMIT;
        else if (inc_p) begin
          minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
          inc_acc   = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // blink phase: free-running half-period counter, restarted visible on field entry and each accepted inc
  always_comb begin
    clr     = inc_acc | ((state_d != state_q) & ((state_d == SET_HOURS) | (state_d == SET_MINUTES)));
    bwrap   = bcnt_q == BW'(BLINK_HALF - 1);
    bcnt_d  = (clr | bwrap) ? '0 : bcnt_q + BW'(1);
    phase_d = clr ? 1'b0 : phase_q ^ bwrap;
  end

  // output decode from next state so every output leaves a flop
  always_comb begin
    run_en_d  = state_d == RUN;
    load_d    = state_d == COMMIT;
    blink_h_d = (state_d == SET_HOURS) & phase_d;
    blink_m_d = (state_d == SET_MINUTES) & phase_d;
  end

  // all state registers, cleared asynchronously to the run state with nothing pending
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      press_q   <= '0;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
      state_q   <= RUN;
      hours_q   <= '0;
      minutes_q <= '0;
      bcnt_q    <= '0;
      phase_q   <= 1'b0;
      run_en_q  <= 1'b1;
      load_q    <= 1'b0;
      blink_h_q <= 1'b0;
      blink_m_q <= 1'b0;
    end else begin
      sync1_q   <= {btn_inc, btn_mode};
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      press_q   <= press_d;
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
      state_q   <= state_d;
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
      run_en_q  <= run_en_d;
      load_q    <= load_d;
      blink_h_q <= blink_h_d;
      blink_m_q <= blink_m_d;
    end
  end

  assign set_hours     = hours_q;
  assign set_minutes   = minutes_q;
  assign set_seconds   = 6'd0;
  assign load          = load_q;
  assign run_en        = run_en_q;
  assign blink_hours   = blink_h_q;
  assign blink_minutes = blink_m_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed self-checking bench for time_set_ctrl
module tb_time_set_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] cur_hours = '0;
  logic [5:0] cur_minutes = '0;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic [5:0] set_seconds;
  logic       load, run_en, blink_hours, blink_minutes;
  int         vec_cnt = 0;
  int         err_cnt = 0;

  time_set_ctrl #(.DEBOUNCE_CYCLES(4), .BLINK_HALF(8)) dut (
    .clk_50MHz(clk), .reset_n(reset_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes),
    .set_hours(set_hours), .set_minutes(set_minutes), .set_seconds(set_seconds),
    .load(load), .run_en(run_en), .blink_hours(blink_hours), .blink_minutes(blink_minutes)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc = i;
    repeat (12) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    logic found;
    int   loads;
    // reset held: outputs pinned while buttons chatter
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      btn_mode = k[0];
      btn_inc = k[1];
      check("rst_run_en", run_en, 1);
      check("rst_load", load, 0);
      check("rst_blink", {blink_hours, blink_minutes}, 0);
      check("rst_set", {set_hours, set_minutes, set_seconds}, 0);
    end
    btn_mode = 0;
    btn_inc = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_run_en", run_en, 1);
    check("post_rst_set_h", set_hours, 0);

    // full edit with wrap: 13:45 -> 00:00
    cur_hours = 13;
    cur_minutes = 45;
    press(1, 0);
    check("cap_h", set_hours, 13);
    check("cap_m", set_minutes, 45);
    check("edit_run_en", run_en, 0);
    for (int k = 0; k < 11; k++) press(0, 1);
    check("wrap_h", set_hours, 0);
    press(1, 0);
    for (int k = 0; k < 15; k++) press(0, 1);
    check("wrap_m", set_minutes, 0);
    check("wrap_m_h", set_hours, 0);
    btn_mode = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (load) found = 1'b1;
    end
    check("load_seen", found, 1);
    check("load_set", {set_hours, set_minutes, set_seconds}, 0);
    check("load_run_en", run_en, 0);
    @(negedge clk);
    check("load_one_cycle", load, 0);
    check("after_load_run_en", run_en, 1);
    btn_mode = 1'b0;
    repeat (12) @(negedge clk);
    check("idle_load", load, 0);

    // bounce on inc in SET_HOURS: no press until held stable
    cur_hours = 4;
    cur_minutes = 10;
    press(1, 0);
    check("cap2_h", set_hours, 4);
    for (int k = 0; k < 20; k++) begin
      btn_inc = k[1];
      @(negedge clk);
    end
    btn_inc = 1'b0;
    repeat (10) @(negedge clk);
    check("bounce_h", set_hours, 4);
    btn_inc = 1'b1;
    repeat (20) @(negedge clk);
    btn_inc = 1'b0;
    repeat (12) @(negedge clk);
    check("hold_once_h", set_hours, 5);

    // simultaneous mode+inc: mode wins, inc dropped
    press(1, 1);
    check("simul_h", set_hours, 5);
    check("simul_run_en", run_en, 0);
    press(0, 1);
    check("simul_now_min", set_minutes, 11);
    check("simul_h_kept", set_hours, 5);

    // reset mid-edit in SET_MINUTES
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (blink_minutes) found = 1'b1;
    end
    check("blink_m_seen", found, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_run_en", run_en, 1);
    check("mid_rst_blink_m", blink_minutes, 0);
    check("mid_rst_load", load, 0);
    @(negedge clk);
    reset_n = 1'b1;
    loads = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (load) loads++;
    end
    check("no_load_after_rst", loads, 0);
    check("edit_discarded", set_hours, 0);
    check("rst_back_run", run_en, 1);

    // blink pattern and capture clamp
    cur_hours = 27;
    cur_minutes = 30;
    btn_mode = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (!run_en) found = 1'b1;
    end
    check("enter_set_h", found, 1);
    check("clamp_h", set_hours, 0);
    check("clamp_m", set_minutes, 30);
    for (int k = 0; k < 32; k++) begin
      if (k != 0) @(negedge clk);
      check("blink_h_pat", blink_hours, (k / 8) % 2);
      check("blink_m_off", blink_minutes, 0);
    end
    btn_mode = 1'b0;
    repeat (12) @(negedge clk);
    btn_inc = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (set_hours == 5'd1) found = 1'b1;
    end
    check("inc_seen", found, 1);
    for (int k = 0; k < 9; k++) begin
      if (k != 0) @(negedge clk);
      check("blink_inc_clr", blink_hours, k / 8);
    end
    btn_inc = 1'b0;
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
